reg_file_sb: RTL and testbench

Parametrised successor of the core's integer register file: two combinational read ports, one write-back port with same-cycle write-through bypass, and synchronous clearing of all registers on reset. It also contains a per-register busy scoreboard. Issue sets a destination busy, write-back clears it, and flush clears every busy bit. The decode stage uses it to detect read-after-write hazards, and the write-back stage drives its write port.

---
 rtl/reg_file_sb.sv | 91 +++++++++
 tb/tb_reg_file_sb.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/reg_file_sb.sv
// Integer register file with two combinational read ports, write-through bypass,
// and a per-register busy scoreboard for read-after-write hazard detection.
module reg_file_sb #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned NREG = 32,
  localparam int unsigned AW  = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] regout1,
  output logic [XLEN-1:0] regout2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic            RegWrite,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic            flush,
  output logic            busy1,
  output logic            busy2,
  output logic [AW:0]     busy_count
);

  localparam int unsigned CW = AW + 1;

  logic [XLEN-1:0] regs [NREG];
  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_nxt;
  logic [CW-1:0]   busy_count_nxt;
  logic            wr_en;
  logic            wr_hit1;
  logic            wr_hit2;

  assign wr_en   = RegWrite && (rd != '0);
  assign wr_hit1 = RegWrite && (rd == rs1);
  assign wr_hit2 = RegWrite && (rd == rs2);

  // Read ports: x0 is zero, otherwise a same-cycle write-back is forwarded.
  always_comb begin
    regout1 = '0;
    if (rs1 != '0) regout1 = wr_hit1 ? write_data : regs[rs1];
  end

  always_comb begin
    regout2 = '0;
    if (rs2 != '0) regout2 = wr_hit2 ? write_data : regs[rs2];
  end

  // A write-back in flight resolves the hazard, so it masks the stored busy bit.
  assign busy1 = busy[rs1] && !wr_hit1 && (rs1 != '0);
  assign busy2 = busy[rs2] && !wr_hit2 && (rs2 != '0);

  // Scoreboard next state: flush beats issue, issue beats write-back clear.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (RegWrite) busy_nxt[rd] = 1'b0;
      if (issue_valid) busy_nxt[issue_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_comb begin
    busy_count_nxt = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      busy_count_nxt = busy_count_nxt + CW'(busy_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy       <= '0;
      busy_count <= '0;
    end else begin
      busy       <= busy_nxt;
      busy_count <= busy_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd] <= write_data;
    end
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: per-cycle reference model on the default instance plus
// directed literal checks, and a 64-bit/16-entry instance for parametrisation.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // default instance
  logic        rst;
  logic [4:0]  rs1, rs2, rd, issue_rd;
  logic [31:0] regout1, regout2, write_data;
  logic        RegWrite, issue_valid, flush, busy1, busy2;
  logic [5:0]  busy_count;

  reg_file_sb dut (
    .clk(clk), .rst(rst), .rs1(rs1), .rs2(rs2), .regout1(regout1), .regout2(regout2),
    .rd(rd), .write_data(write_data), .RegWrite(RegWrite), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .flush(flush), .busy1(busy1), .busy2(busy2), .busy_count(busy_count)
  );

  // 64-bit, 16-register instance
  logic        w_rst;
  logic [3:0]  w_rs1, w_rs2, w_rd, w_issue_rd;
  logic [63:0] w_regout1, w_regout2, w_write_data;
  logic        w_RegWrite, w_issue_valid, w_flush, w_busy1, w_busy2;
  logic [4:0]  w_busy_count;

  reg_file_sb #(.XLEN(64), .NREG(16)) dut_w (
    .clk(clk), .rst(w_rst), .rs1(w_rs1), .rs2(w_rs2), .regout1(w_regout1), .regout2(w_regout2),
    .rd(w_rd), .write_data(w_write_data), .RegWrite(w_RegWrite), .issue_valid(w_issue_valid),
    .issue_rd(w_issue_rd), .flush(w_flush), .busy1(w_busy1), .busy2(w_busy2),
    .busy_count(w_busy_count)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: architectural register contents and the set of pending destinations.
  logic [31:0] m_regs [32];
  logic [31:0] m_busy;

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    m_busy = '0;
  end

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0;
    end else begin
      if (RegWrite && rd != 0) m_regs[rd] = write_data;
      if (flush) m_busy = '0;
      else begin
        if (RegWrite) m_busy[rd] = 1'b0;
        if (issue_valid) m_busy[issue_rd] = 1'b1;
      end
      m_busy[0] = 1'b0;
    end
  end

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (RegWrite && rd == idx) return write_data;
    return m_regs[idx];
  endfunction

  function automatic logic model_busy(input logic [4:0] idx);
    if (idx == 0) return 1'b0;
    if (RegWrite && rd == idx) return 1'b0;
    return m_busy[idx];
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_regout1", 64'(regout1), 64'(model_read(rs1)));
      check("m_regout2", 64'(regout2), 64'(model_read(rs2)));
      check("m_busy1", 64'(busy1), 64'(model_busy(rs1)));
      check("m_busy2", 64'(busy2), 64'(model_busy(rs2)));
      check("m_busy_count", 64'(busy_count), 64'($countones(m_busy)));
    end
  end

  task automatic idle();
    rst = 0; rs1 = 0; rs2 = 0; rd = 0; issue_rd = 0; write_data = 0;
    RegWrite = 0; issue_valid = 0; flush = 0;
    w_rst = 0; w_rs1 = 0; w_rs2 = 0; w_rd = 0; w_issue_rd = 0; w_write_data = 0;
    w_RegWrite = 0; w_issue_valid = 0; w_flush = 0;
  endtask

  // Advance past the next rising edge and return all controls to idle.
  task automatic cyc();
    @(posedge clk);
    #1;
    idle();
  endtask

  initial begin
    idle();
    rst = 1; w_rst = 1;
    cyc();
    chk_en = 1;

    // reset clears a written register; outputs hold pre-edge state while rst is high
    RegWrite = 1; rd = 5; write_data = 32'hDEADBEEF; rs1 = 5;
    @(negedge clk); check("bypass_x5", 64'(regout1), 64'hDEADBEEF);
    cyc(); rst = 1; rs1 = 5;
    @(negedge clk); check("pre_reset_x5", 64'(regout1), 64'hDEADBEEF);
    cyc(); rs1 = 5;
    @(negedge clk);
    check("reset_x5", 64'(regout1), 64'h0);
    check("reset_count", 64'(busy_count), 64'h0);
    check("reset_busy1", 64'(busy1), 64'h0);

    // bypass and retention on x7, x0 writes ignored
    cyc(); RegWrite = 1; rd = 7; write_data = 32'h12345678; rs1 = 7; rs2 = 7;
    @(negedge clk);
    check("bypass_p1", 64'(regout1), 64'h12345678);
    check("bypass_p2", 64'(regout2), 64'h12345678);
    cyc(); rs1 = 7; rs2 = 7;
    @(negedge clk); check("retain_x7", 64'(regout2), 64'h12345678);
    cyc(); RegWrite = 1; rd = 0; write_data = 32'hFFFFFFFF; issue_valid = 1; issue_rd = 0;
    @(negedge clk); check("x0_bypass", 64'(regout1), 64'h0);
    cyc();
    @(negedge clk);
    check("x0_stored", 64'(regout1), 64'h0);
    check("x0_no_busy", 64'(busy_count), 64'h0);

    // scoreboard: issue x3, write back three cycles later
    cyc(); issue_valid = 1; issue_rd = 3; rs1 = 3;
    @(negedge clk); check("sb_t0", 64'(busy1), 64'h0);
    cyc(); rs1 = 3;
    @(negedge clk); check("sb_t1", 64'(busy1), 64'h1); check("sb_cnt1", 64'(busy_count), 64'h1);
    cyc(); rs1 = 3;
    @(negedge clk); check("sb_t2", 64'(busy1), 64'h1);
    cyc(); rs1 = 3; RegWrite = 1; rd = 3; write_data = 32'h33;
    @(negedge clk); check("sb_t3", 64'(busy1), 64'h0); check("sb_cnt3", 64'(busy_count), 64'h1);
    cyc(); rs1 = 3;
    @(negedge clk); check("sb_t4", 64'(busy1), 64'h0); check("sb_cnt4", 64'(busy_count), 64'h0);

    // simultaneous issue and write-back on busy x4
    cyc(); issue_valid = 1; issue_rd = 4;
    cyc(); issue_valid = 1; issue_rd = 4; RegWrite = 1; rd = 4; write_data = 32'hA5A5A5A5; rs1 = 4;
    @(negedge clk); check("setclr_cnt_pre", 64'(busy_count), 64'h1);
    cyc(); rs1 = 4;
    @(negedge clk);
    check("setclr_data", 64'(regout1), 64'hA5A5A5A5);
    check("setclr_busy", 64'(busy1), 64'h1);
    check("setclr_cnt", 64'(busy_count), 64'h1);
    cyc(); RegWrite = 1; rd = 4; write_data = 32'h4;

    // flush drops the busy set, a same-cycle issue, but not the write
    cyc(); issue_valid = 1; issue_rd = 1;
    cyc(); issue_valid = 1; issue_rd = 2;
    cyc(); issue_valid = 1; issue_rd = 9;
    cyc();
    @(negedge clk); check("flush_cnt_pre", 64'(busy_count), 64'h3);
    cyc(); flush = 1; issue_valid = 1; issue_rd = 10; RegWrite = 1; rd = 2; write_data = 32'h55;
    cyc(); rs1 = 10; rs2 = 2;
    @(negedge clk);
    check("flush_cnt", 64'(busy_count), 64'h0);
    check("flush_x10", 64'(busy1), 64'h0);
    check("flush_x2", 64'(regout2), 64'h55);

    // mixed traffic checked by the model alone
    for (int i = 0; i < 300; i++) begin
      cyc();
      rs1 = 5'($urandom); rs2 = 5'($urandom); rd = 5'($urandom % 8); issue_rd = 5'($urandom % 8);
      write_data = $urandom; RegWrite = 1'($urandom); issue_valid = 1'($urandom);
      flush = ($urandom % 16) == 0; rst = ($urandom % 64) == 0;
    end
    cyc();

    // 64-bit, 16-register configuration
    for (int i = 1; i < 16; i++) begin
      cyc(); w_issue_valid = 1; w_issue_rd = 4'(i);
    end
    cyc();
    @(negedge clk); check("w_count_full", 64'(w_busy_count), 64'd15);
    cyc(); w_issue_valid = 1; w_issue_rd = 4'd15;
    @(negedge clk); check("w_reissue_pre", 64'(w_busy_count), 64'd15);
    cyc(); w_RegWrite = 1; w_rd = 4'd15; w_write_data = 64'h0123456789ABCDEF; w_rs1 = 4'd15;
    @(negedge clk);
    check("w_bypass", w_regout1, 64'h0123456789ABCDEF);
    check("w_bypass_busy", 64'(w_busy1), 64'h0);
    cyc(); w_rs1 = 4'd15; w_rs2 = 4'd15;
    @(negedge clk);
    check("w_read1", w_regout1, 64'h0123456789ABCDEF);
    check("w_read2", w_regout2, 64'h0123456789ABCDEF);
    check("w_count_after", 64'(w_busy_count), 64'd14);
    cyc(); w_flush = 1;
    cyc();
    @(negedge clk); check("w_flush_cnt", 64'(w_busy_count), 64'd0);

    cyc();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
